// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    // E-stage operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;   // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;   // result from W
    localparam logic [1:0] FWD_MEM = 2'b10;   // result from M

    // Pipeline stage index
    typedef enum logic [2:0] {
        STAGE_F = 3'd0,
        STAGE_D = 3'd1,
        STAGE_E = 3'd2,
        STAGE_M = 3'd3,
        STAGE_W = 3'd4
    } stage_e;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks an in-flight multi-cycle MDU op with a down-counter.
// Ports:
//   clk, resetn  clock, async active-low reset
//   start        accepted MDU op leaving E this cycle (already qualified)
//   mduBusy      an MDU op is still executing
module mdu_busy_tracker #(
    parameter int unsigned MDU_CYCLES = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic mduBusy
);

    localparam int unsigned CNT_BITS = ($clog2(MDU_CYCLES) > 6) ? $clog2(MDU_CYCLES) : 6;
    localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(MDU_CYCLES - 1);

    logic [CNT_BITS-1:0] cnt;

    // Start cycle counts as the first cycle, so the remaining latency is loaded.
    // A start while busy simply reloads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_BITS'(1);
        end
    end

    assign mduBusy = (cnt != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard detection, forwarding and stage stall/flush control for the
// 5-stage pipeline, with MDU busy tracking, data-memory wait, exception
// flush and a saturating stall-cycle counter.
// Ports:
//   D-stage:  rsD, rtD, branchD, hiloreadD
//   E-stage:  rsE, rtE, writeregE, regwriteE, memtoregE, mdustartE
//   M-stage:  writeregM, regwriteM, memtoregM, dmem_waitM, excM
//   W-stage:  writeregW, regwriteW
//   Outputs:  forwardAE/BE (E mux select), forwardAD/BD (D compare forward),
//             stallF..stallM, flushD..flushW, mdu_busy, stall_cnt
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MDU_CYCLES = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              hiloreadD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mdustartE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              dmem_waitM,
    input  logic              excM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic lwStall;
    logic branchStall;
    logic mduStall;
    logic mduStart;

    // E operand forwarding; M is the younger producer so it wins over W
    always_comb begin
        forwardAE = FWD_RF;
        if (rsE != '0 && rsE == writeregM && regwriteM)      forwardAE = FWD_MEM;
        else if (rsE != '0 && rsE == writeregW && regwriteW) forwardAE = FWD_WB;

        forwardBE = FWD_RF;
        if (rtE != '0 && rtE == writeregM && regwriteM)      forwardBE = FWD_MEM;
        else if (rtE != '0 && rtE == writeregW && regwriteW) forwardBE = FWD_WB;
    end

    // Branch comparator in D can only take the M result
    assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    assign lwStall     = memtoregE && ((rsD == rtE) || (rtD == rtE));
    assign branchStall = branchD &&
                         ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                          (memtoregM && (writeregM == rsD || writeregM == rtD)));
    assign mduStall    = hiloreadD && (mdu_busy || mdustartE);

    // Stall/flush priority: exception, memory wait, D-stage hazards
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (dmem_waitM) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (lwStall || branchStall || mduStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // MDU op is accepted only when it actually leaves E and is not squashed
    assign mduStart = mdustartE && !stallE && !excM;

    mdu_busy_tracker #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mduTracker (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mduStart),
        .mduBusy (mdu_busy)
    );

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stallF && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MDU_CYCLES=4, CNT_W=4).
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_hazard_unit_mc;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned MDU_CYCLES = 4;
    localparam int unsigned CNT_W      = 4;

    logic              clk;
    logic              resetn;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic              branchD, hiloreadD, regwriteE, memtoregE, mdustartE;
    logic              regwriteM, memtoregM, dmem_waitM, excM, regwriteW;
    logic [1:0]        forwardAE, forwardBE;
    logic              forwardAD, forwardBD;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, flushM, flushW;
    logic              mdu_busy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_unit_mc #(
        .REG_AW     (REG_AW),
        .MDU_CYCLES (MDU_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rsD        (rsD),
        .rtD        (rtD),
        .branchD    (branchD),
        .hiloreadD  (hiloreadD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeregE  (writeregE),
        .regwriteE  (regwriteE),
        .memtoregE  (memtoregE),
        .mdustartE  (mdustartE),
        .writeregM  (writeregM),
        .regwriteM  (regwriteM),
        .memtoregM  (memtoregM),
        .dmem_waitM (dmem_waitM),
        .excM       (excM),
        .writeregW  (writeregW),
        .regwriteW  (regwriteW),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .forwardAD  (forwardAD),
        .forwardBD  (forwardBD),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .flushW     (flushW),
        .mdu_busy   (mdu_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of stall/flush outputs: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
    logic [7:0] ctl;
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

    task automatic clearInputs();
        rsD = '0; rtD = '0; branchD = 0; hiloreadD = 0;
        rsE = '0; rtE = '0; writeregE = '0; regwriteE = 0; memtoregE = 0; mdustartE = 0;
        writeregM = '0; regwriteM = 0; memtoregM = 0; dmem_waitM = 0; excM = 0;
        writeregW = '0; regwriteW = 0;
    endtask

    // Advance one cycle: next falling edge, with all inputs idle
    task automatic nextCycle();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clearInputs();
        #12;
        checks++;
        if ({forwardAE, forwardBE, forwardAD, forwardBD, ctl, mdu_busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {forwardAE, forwardBE, forwardAD, forwardBD, ctl, mdu_busy});
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d required 0", stall_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_forwarding();
        nextCycle();
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1; writeregW = 5'd5; regwriteW = 1; rsD = 5'd5;
        #1;
        checks++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_mem_prio got AE=%b BE=%b required AE=10 BE=00", forwardAE, forwardBE);
        end
        checks++;
        if (forwardAD !== 1'b1 || forwardBD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_d_mem got AD=%b BD=%b required AD=1 BD=0", forwardAD, forwardBD);
        end
        nextCycle();
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 0; writeregW = 5'd5; regwriteW = 1; rtE = 5'd5; rtD = 5'd5;
        #1;
        checks++;
        if (forwardAE !== 2'b01 || forwardBE !== 2'b01 || forwardBD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_wb got AE=%b BE=%b BD=%b required 01 01 0", forwardAE, forwardBE, forwardBD);
        end
        nextCycle();
        rsE = 5'd0; writeregM = 5'd0; regwriteM = 1; writeregW = 5'd0; regwriteW = 1; rsD = 5'd0;
        #1;
        checks++;
        if (forwardAE !== 2'b00 || forwardAD !== 1'b0) begin
            errors++;
            $display("FAIL fwd_r0 got AE=%b AD=%b required 00 0", forwardAE, forwardAD);
        end
    endtask

    task automatic test_load_use();
        nextCycle();
        memtoregE = 1; rtE = 5'd7; rtD = 5'd7; rsD = 5'd3;
        #1;
        checks++;
        if (ctl !== 8'b1100_0100) begin
            errors++;
            $display("FAIL lwstall got %b required 11000100", ctl);
        end
        nextCycle();
        memtoregE = 0; rtE = 5'd7; rtD = 5'd7; rsD = 5'd3;
        #1;
        checks++;
        if (ctl !== 8'b0 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lw_clear got ctl=%b cnt=%0d required 0 cnt=1", ctl, stall_cnt);
        end
        // Branch in D depending on an ALU result in E
        nextCycle();
        branchD = 1; regwriteE = 1; writeregE = 5'd4; rsD = 5'd4; rtD = 5'd9;
        #1;
        checks++;
        if (ctl !== 8'b1100_0100) begin
            errors++;
            $display("FAIL branchstall got %b required 11000100", ctl);
        end
    endtask

    task automatic test_mdu();
        nextCycle();  // cycle t
        mdustartE = 1;
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL mdu_t got busy=%b cnt=%0d required busy=0 cnt=2", mdu_busy, stall_cnt);
        end
        nextCycle();  // t+1
        #1;
        checks++;
        if (mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL mdu_t1 got busy=%b required 1", mdu_busy);
        end
        nextCycle();  // t+2
        hiloreadD = 1;
        #1;
        checks++;
        if (mdu_busy !== 1'b1 || stallF !== 1'b1 || flushE !== 1'b1) begin
            errors++;
            $display("FAIL mdu_t2 got busy=%b stallF=%b flushE=%b required 1 1 1", mdu_busy, stallF, flushE);
        end
        nextCycle();  // t+3
        #1;
        checks++;
        if (mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL mdu_t3 got busy=%b required 1", mdu_busy);
        end
        nextCycle();  // t+4
        hiloreadD = 1;
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || stallF !== 1'b0) begin
            errors++;
            $display("FAIL mdu_t4 got busy=%b stallF=%b required 0 0", mdu_busy, stallF);
        end
    endtask

    task automatic test_dmem_wait();
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            dmem_waitM = 1; memtoregE = 1; rtE = 5'd7; rtD = 5'd7;
            #1;
            checks++;
            if (ctl !== 8'b1111_0001 || stall_cnt !== 4'(3 + i)) begin
                errors++;
                $display("FAIL dmem_wait[%0d] got ctl=%b cnt=%0d required 11110001 cnt=%0d", i, ctl, stall_cnt, 3 + i);
            end
        end
        nextCycle();
        #1;
        checks++;
        if (stall_cnt !== 4'd6 || ctl !== 8'b0) begin
            errors++;
            $display("FAIL dmem_after got cnt=%0d ctl=%b required 6 0", stall_cnt, ctl);
        end
        // Start held in a stalled E must not launch the MDU
        nextCycle();
        dmem_waitM = 1; mdustartE = 1;
        nextCycle();
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || stall_cnt !== 4'd7) begin
            errors++;
            $display("FAIL stalled_start got busy=%b cnt=%0d required 0 7", mdu_busy, stall_cnt);
        end
    endtask

    task automatic test_exception();
        nextCycle();
        excM = 1; dmem_waitM = 1; mdustartE = 1; memtoregE = 1; rtE = 5'd2; rsD = 5'd2;
        #1;
        checks++;
        if (ctl !== 8'b0000_1110) begin
            errors++;
            $display("FAIL exc_prio got %b required 00001110", ctl);
        end
        nextCycle();
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || stall_cnt !== 4'd7) begin
            errors++;
            $display("FAIL exc_suppress got busy=%b cnt=%0d required 0 7", mdu_busy, stall_cnt);
        end
        // An older in-flight MDU op survives an exception
        mdustartE = 1;
        nextCycle();
        excM = 1;
        nextCycle();
        #1;
        checks++;
        if (mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL exc_keeps_mdu got busy=%b required 1", mdu_busy);
        end
        nextCycle();
        nextCycle();
        nextCycle();
        #1;
        checks++;
        if (mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_drain got busy=%b required 0", mdu_busy);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            memtoregE = 1; rtE = 5'd7; rtD = 5'd7;
        end
        nextCycle();
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturate got %0d required 15", stall_cnt);
        end
    endtask

    task automatic test_reset_midop();
        nextCycle();
        mdustartE = 1;
        nextCycle();
        #1;
        checks++;
        if (mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %b required 1", mdu_busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'd0 || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d busy=%b required 0 0", stall_cnt, mdu_busy);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_dmem_wait();
        test_exception();
        test_saturation();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
